// File: rtl/sel_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready intake, level-hold and timed-pulse modes.
// Optional per-line saturating hit counters are built only when DECODER_HIT_CNT_EN is defined.
module sel_decoder_seq #(
  parameter  int SEL_W     = 2,
  parameter  int PULSE_LEN = 3,
  parameter  int CNT_W     = 8,
  localparam int OUT_W     = 2 ** SEL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
  input  logic                   mode,
  output logic [OUT_W-1:0]       out,
  output logic                   done,
  output logic [OUT_W*CNT_W-1:0] hit_cnt
);

  localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t              r_state;
  logic [OUT_W-1:0]    r_out;
  logic                r_done;
  logic [PCNT_W-1:0]   r_pcnt;

  state_t              w_state_nxt;
  logic [OUT_W-1:0]    w_out_nxt;
  logic                w_done_nxt;
  logic [PCNT_W-1:0]   w_pcnt_nxt;
  logic                w_accept;
  logic [OUT_W-1:0]    w_onehot;

  // A pulse in flight blocks intake; IDLE and HOLD always accept.
  assign in_ready = (r_state != S_PULSE);
  assign w_accept = in_valid & in_ready;
  assign w_onehot = OUT_W'(1) << sel;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    w_pcnt_nxt  = r_pcnt;

    case (r_state)
      S_PULSE: begin
        if (r_pcnt == '0) begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = '0;
        end else begin
          w_pcnt_nxt = r_pcnt - PCNT_W'(1);
          // done lands on the final high cycle, i.e. when the counter reaches zero.
          w_done_nxt = (r_pcnt == PCNT_W'(1));
        end
      end
      default: begin
        if (w_accept) begin
          if (!en) begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else if (!mode) begin
            w_state_nxt = S_HOLD;
            w_out_nxt   = w_onehot;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_PULSE;
            w_out_nxt   = w_onehot;
            w_pcnt_nxt  = PULSE_LOAD;
            w_done_nxt  = (PULSE_LEN == 1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  assign out  = r_out;
  assign done = r_done;

`ifdef DECODER_HIT_CNT_EN
  for (genvar k = 0; k < OUT_W; k++) begin : g_hit
    logic [CNT_W-1:0] r_hit;
    logic             w_hit_inc;

    assign w_hit_inc = w_accept & en & (sel == SEL_W'(k));

    // NOTE: the counters form a small register file that must read zero after reset, so each one is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hit <= '0;
      end else if (w_hit_inc && (r_hit != '1)) begin
        r_hit <= r_hit + CNT_W'(1);
      end
    end

    assign hit_cnt[k*CNT_W +: CNT_W] = r_hit;
  end
`else
  assign hit_cnt = '0;
`endif

  // Structural invariants of the decode: zero in IDLE, exactly one line otherwise.
  a_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_IDLE) |-> (r_out == '0));
  a_busy_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != S_IDLE) |-> $onehot(r_out));

endmodule

// File: tb/tb_sel_decoder_seq.sv
// Scoreboard bench for sel_decoder_seq: requests push expected responses, per-DUT monitors pop on done.
// Instance a is the default build; instance b uses PULSE_LEN=1 and CNT_W=2.
module tb_sel_decoder_seq;

`ifdef DECODER_HIT_CNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  out;
    logic [3:0]  prev;
    int          run;
    logic        rdy;
    logic [31:0] hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_en, a_mode, a_done;
  logic [1:0]  a_sel;
  logic [3:0]  a_out;
  logic [31:0] a_hit;

  logic        b_valid, b_ready, b_en, b_mode, b_done;
  logic [1:0]  b_sel;
  logic [3:0]  b_out;
  logic [7:0]  b_hit;

  sel_decoder_seq #(.SEL_W(2), .PULSE_LEN(3), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .sel(a_sel),
    .en(a_en), .mode(a_mode), .out(a_out), .done(a_done), .hit_cnt(a_hit)
  );

  sel_decoder_seq #(.SEL_W(2), .PULSE_LEN(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .sel(b_sel),
    .en(b_en), .mode(b_mode), .out(b_out), .done(b_done), .hit_cnt(b_hit)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   hits_a[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [3:0] o, input logic [3:0] p,
                       input int r, input logic rd, input logic [31:0] h);
    check({tag, "_out"},   32'(o),  32'(e.out));
    check({tag, "_prev"},  32'(p),  32'(e.prev));
    check({tag, "_run"},   r,       e.run);
    check({tag, "_ready"}, 32'(rd), 32'(e.rdy));
    check({tag, "_hit"},   h,       e.hit);
  endtask

  // Monitor state: current out value, the value before it, and how many cycles it has been stable.
  logic [3:0] a_last, a_prev, b_last, b_prev;
  int         a_run, b_run;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_last = '0; a_prev = '0; a_run = 1;
    end else begin
      if (a_out == a_last) a_run++;
      else begin a_prev = a_last; a_last = a_out; a_run = 1; end
      check("a_onehot0", 32'($onehot0(a_out)), 32'd1);
      if (a_done) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_errors++;
          $display("FAIL a_done_unexpected: got done=1, expected no pending request");
        end else begin
          score("a", q_a.pop_front(), a_out, a_prev, a_run, a_ready, a_hit);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_last = '0; b_prev = '0; b_run = 1;
    end else begin
      if (b_out == b_last) b_run++;
      else begin b_prev = b_last; b_last = b_out; b_run = 1; end
      check("b_onehot0", 32'($onehot0(b_out)), 32'd1);
      if (b_done) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_errors++;
          $display("FAIL b_done_unexpected: got done=1, expected no pending request");
        end else begin
          score("b", q_b.pop_front(), b_out, b_prev, b_run, b_ready, {24'd0, b_hit});
        end
      end
    end
  end

  // Drive a request at posedge+1 and hold it until accepted; returns the number of stalled cycles.
  task automatic send(input bit use_b, input logic [1:0] s, input logic e, input logic m,
                      input bit push, input exp_t x, output int waited);
    bit acc;
    if (use_b) begin
      b_valid = 1'b1; b_sel = s; b_en = e; b_mode = m;
      if (push) q_b.push_back(x);
    end else begin
      a_valid = 1'b1; a_sel = s; a_en = e; a_mode = m;
      if (push) q_a.push_back(x);
    end
    waited = 0;
    forever begin
      acc = use_b ? b_ready : a_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 20) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: got no accept after %0d cycles, expected acceptance", waited);
        break;
      end
    end
  endtask

  function automatic logic [31:0] a_hit_vec();
    logic [31:0] v = '0;
    if (HIT_EN)
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(hits_a[k]);
    return v;
  endfunction

  task automatic req_a(input logic [1:0] s, input logic e, input logic m, input logic [3:0] prev,
                       input int run, input logic rdy, input bit push, output int waited);
    exp_t x;
    logic [3:0] one = 4'b0001;
    if (e && hits_a[s] < 255) hits_a[s]++;
    x.out  = e ? (one << s) : 4'b0000;
    x.prev = prev;
    x.run  = run;
    x.rdy  = rdy;
    x.hit  = a_hit_vec();
    send(1'b0, s, e, m, push, x, waited);
  endtask

  task automatic req_b(input logic [1:0] s, input logic m, input logic [3:0] o, input int run,
                       input logic rdy, input logic [7:0] hit, output int waited);
    exp_t x;
    x.out  = o;
    x.prev = 4'b0000;
    x.run  = run;
    x.rdy  = rdy;
    x.hit  = HIT_EN ? {24'd0, hit} : 32'd0;
    send(1'b1, s, 1'b1, m, 1'b1, x, waited);
  endtask

  initial begin
    int w;
    int sat_seq[5] = '{1, 2, 3, 3, 3};
    logic [3:0] one = 4'b0001;

    a_valid = 1'b0; a_sel = '0; a_en = 1'b0; a_mode = 1'b0;
    b_valid = 1'b0; b_sel = '0; b_en = 1'b0; b_mode = 1'b0;
    for (int k = 0; k < 4; k++) hits_a[k] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out",   32'(a_out),   32'h0);
    check("rst_done",  32'(a_done),  32'h0);
    check("rst_ready", 32'(a_ready), 32'h1);
    check("rst_hit",   a_hit,        32'h0);
    check("rst_b_out", 32'(b_out),   32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_done", 32'(a_done), 32'h0);

    // Level-hold sweep, back to back: no stall, no zero gap between selects.
    for (int s = 0; s < 4; s++) begin
      req_a(2'(s), 1'b1, 1'b0, (s == 0) ? 4'b0000 : (one << (s - 1)), 1, 1'b1, 1'b1, w);
      check("sweep_stall", w, 0);
    end

    // HOLD -> PULSE on sel 2, then a held request that must wait out the pulse.
    req_a(2'd2, 1'b1, 1'b1, 4'b1000, 3, 1'b0, 1'b1, w);
    check("pulse_accept_stall", w, 0);
    req_a(2'd3, 1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b1, w);
    check("held_during_pulse", w, 3);

    // Disable from HOLD(1000): clears out, sel-1 counter untouched.
    req_a(2'd1, 1'b0, 1'b0, 4'b1000, 1, 1'b1, 1'b1, w);
    a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the second cycle of a sel-3 pulse.
    req_a(2'd3, 1'b1, 1'b1, 4'b0000, 0, 1'b0, 1'b0, w);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) hits_a[k] = 0;
    #1;
    check("midpulse_rst_out",   32'(a_out),   32'h0);
    check("midpulse_rst_ready", 32'(a_ready), 32'h1);
    check("midpulse_rst_hit",   a_hit,        32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("after_rst_ready", 32'(a_ready), 32'h1);
    check("after_rst_out",   32'(a_out),   32'h0);
    req_a(2'd2, 1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b1, w);
    req_a(2'd1, 1'b1, 1'b1, 4'b0100, 3, 1'b0, 1'b1, w);
    a_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pulse_end_out",   32'(a_out),   32'h0);
    check("pulse_end_ready", 32'(a_ready), 32'h1);

    // PULSE_LEN=1 instance: two held pulses on sel 1 separated by one idle cycle.
    req_b(2'd1, 1'b1, 4'b0010, 1, 1'b0, 8'h04, w);
    check("b_first_stall", w, 0);
    req_b(2'd1, 1'b1, 4'b0010, 1, 1'b0, 8'h08, w);
    check("b_gap_stall", w, 1);
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b_pulse_end_out", 32'(b_out), 32'h0);

    // Fresh counters, then saturation of line 0 at 3.
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) hits_a[k] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) begin
      req_b(2'd0, 1'b0, 4'b0001, n + 1, 1'b1, 8'(sat_seq[n]), w);
      check("b_sat_stall", w, 0);
    end
    b_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
